// File: rtl/mc_sequencer.sv
// Multi-cycle MIPS-subset control sequencer: FETCH/DECODE/EXEC/MEM/WB with
// memory wait timeout. Control outputs are combinational decodes of the
// current state and the op/funct fields latched when the IR is loaded.
module mc_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic        mem_ready_i,
    input  logic        zero_i,
    output logic [2:0]  state_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic        reg_write_o,
    output logic [1:0]  pc_src_o,
    output logic [1:0]  reg_dst_o,
    output logic [1:0]  wb_sel_o,
    output logic        alu_src_b_o,
    output logic        retire_o,
    output logic        inst_invalid_o,
    output logic        bus_err_o
);

    localparam int unsigned ST_W  = 3;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CLS_W = 4;

    localparam logic [ST_W-1:0] ST_FETCH  = 3'd0;
    localparam logic [ST_W-1:0] ST_DECODE = 3'd1;
    localparam logic [ST_W-1:0] ST_EXEC   = 3'd2;
    localparam logic [ST_W-1:0] ST_MEM    = 3'd3;
    localparam logic [ST_W-1:0] ST_WB     = 3'd4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [CLS_W-1:0] CL_INV  = 4'd0;
    localparam logic [CLS_W-1:0] CL_IALU = 4'd1;
    localparam logic [CLS_W-1:0] CL_RALU = 4'd2;
    localparam logic [CLS_W-1:0] CL_JR   = 4'd3;
    localparam logic [CLS_W-1:0] CL_LW   = 4'd4;
    localparam logic [CLS_W-1:0] CL_SW   = 4'd5;
    localparam logic [CLS_W-1:0] CL_BEQ  = 4'd6;
    localparam logic [CLS_W-1:0] CL_BNE  = 4'd7;
    localparam logic [CLS_W-1:0] CL_J    = 4'd8;
    localparam logic [CLS_W-1:0] CL_JAL  = 4'd9;

    logic [ST_W-1:0]  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       op_q, op_d;
    logic [5:0]       funct_q, funct_d;
    logic [CLS_W-1:0] cls_c;
    logic             timeout_c;

    // Only op and funct matter to the sequencer; the operand fields do not.
    logic unused_inst_bits;
    assign unused_inst_bits = ^inst_i[25:6];

    // Final wait cycle with memory still not ready aborts the request.
    assign timeout_c = (cnt_q == CNT_LAST) && !mem_ready_i;

    // Classify the latched instruction.
    always_comb begin
        cls_c = CL_INV;
        case (op_q)
            6'b001101, 6'b001100, 6'b001001, 6'b001111: cls_c = CL_IALU;
            6'b100011: cls_c = CL_LW;
            6'b101011: cls_c = CL_SW;
            6'b000100: cls_c = CL_BEQ;
            6'b000101: cls_c = CL_BNE;
            6'b000010: cls_c = CL_J;
            6'b000011: cls_c = CL_JAL;
            6'b000000: begin
                case (funct_q)
                    6'b100001, 6'b100011, 6'b100100, 6'b100101: cls_c = CL_RALU;
                    6'b001000: cls_c = CL_JR;
                    default:   cls_c = CL_INV;
                endcase
            end
            default: cls_c = CL_INV;
        endcase
    end

    // State, wait counter and latched op/funct registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            cnt_q   <= '0;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            funct_q <= funct_d;
        end
    end

    // Next-state, wait counter and op/funct capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        funct_d = funct_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready_i) begin
                    state_d = ST_DECODE;
                    op_d    = inst_i[31:26];
                    funct_d = inst_i[5:0];
                end else if (timeout_c) begin
                    // Re-entering FETCH restarts the wait window.
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                case (cls_c)
                    CL_J, CL_JR, CL_INV: state_d = ST_FETCH;
                    CL_JAL:              state_d = ST_WB;
                    default:             state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (cls_c)
                    CL_BEQ, CL_BNE: state_d = ST_FETCH;
                    CL_LW, CL_SW:   state_d = ST_MEM;
                    default:        state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (mem_ready_i) begin
                    state_d = (cls_c == CL_SW) ? ST_FETCH : ST_WB;
                end else if (timeout_c) begin
                    state_d = ST_FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WB:   state_d = ST_FETCH;
            default: state_d = ST_FETCH;
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Control output decode; everything is held low while reset is asserted.
    always_comb begin
        state_o        = ST_FETCH;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        ir_write_o     = 1'b0;
        pc_write_o     = 1'b0;
        reg_write_o    = 1'b0;
        pc_src_o       = 2'b00;
        reg_dst_o      = 2'b00;
        wb_sel_o       = 2'b00;
        alu_src_b_o    = 1'b0;
        retire_o       = 1'b0;
        inst_invalid_o = 1'b0;
        bus_err_o      = 1'b0;
        if (!rst) begin
            state_o = state_q;
            case (state_q)
                ST_FETCH: begin
                    mem_req_o = 1'b1;
                    if (mem_ready_i) begin
                        ir_write_o = 1'b1;
                        pc_write_o = 1'b1;
                    end else if (timeout_c) begin
                        bus_err_o = 1'b1;
                    end
                end
                ST_DECODE: begin
                    case (cls_c)
                        CL_J: begin
                            pc_write_o = 1'b1;
                            pc_src_o   = 2'b10;
                            retire_o   = 1'b1;
                        end
                        CL_JR: begin
                            pc_write_o = 1'b1;
                            pc_src_o   = 2'b11;
                            retire_o   = 1'b1;
                        end
                        CL_JAL: begin
                            pc_write_o = 1'b1;
                            pc_src_o   = 2'b10;
                        end
                        CL_INV:  inst_invalid_o = 1'b1;
                        default: ;
                    endcase
                end
                ST_EXEC: begin
                    alu_src_b_o = (cls_c == CL_IALU) || (cls_c == CL_LW) || (cls_c == CL_SW);
                    if (cls_c == CL_BEQ || cls_c == CL_BNE) begin
                        pc_write_o = (cls_c == CL_BEQ) ? zero_i : !zero_i;
                        pc_src_o   = 2'b01;
                        retire_o   = 1'b1;
                    end
                end
                ST_MEM: begin
                    mem_req_o = 1'b1;
                    mem_we_o  = (cls_c == CL_SW);
                    if (mem_ready_i) begin
                        retire_o = (cls_c == CL_SW);
                    end else if (timeout_c) begin
                        bus_err_o = 1'b1;
                    end
                end
                ST_WB: begin
                    reg_write_o = 1'b1;
                    retire_o    = 1'b1;
                    case (cls_c)
                        CL_RALU: reg_dst_o = 2'b01;
                        CL_JAL: begin
                            reg_dst_o = 2'b10;
                            wb_sel_o  = 2'b10;
                        end
                        CL_LW:   wb_sel_o = 2'b01;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: directed and random instructions checked per cycle
// against an instruction-level model of the control sequence.
module tb_mc_sequencer;

    localparam int TO = 16;

    localparam int K_INV  = 0;
    localparam int K_IALU = 1;
    localparam int K_RALU = 2;
    localparam int K_JR   = 3;
    localparam int K_LW   = 4;
    localparam int K_SW   = 5;
    localparam int K_BEQ  = 6;
    localparam int K_BNE  = 7;
    localparam int K_J    = 8;
    localparam int K_JAL  = 9;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       we;
        logic       irw;
        logic       pcw;
        logic       rgw;
        logic [1:0] pcs;
        logic [1:0] rdst;
        logic [1:0] wbs;
        logic       alub;
        logic       ret;
        logic       inv;
        logic       berr;
    } obs_t;

    logic        clk;
    logic        rst;
    logic [31:0] inst;
    logic        mem_ready;
    logic        zero;
    logic [2:0]  state_o;
    logic        mem_req_o, mem_we_o, ir_write_o, pc_write_o, reg_write_o;
    logic [1:0]  pc_src_o, reg_dst_o, wb_sel_o;
    logic        alu_src_b_o, retire_o, inst_invalid_o, bus_err_o;

    int total;
    int bad;

    mc_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_i         (inst),
        .mem_ready_i    (mem_ready),
        .zero_i         (zero),
        .state_o        (state_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .ir_write_o     (ir_write_o),
        .pc_write_o     (pc_write_o),
        .reg_write_o    (reg_write_o),
        .pc_src_o       (pc_src_o),
        .reg_dst_o      (reg_dst_o),
        .wb_sel_o       (wb_sel_o),
        .alu_src_b_o    (alu_src_b_o),
        .retire_o       (retire_o),
        .inst_invalid_o (inst_invalid_o),
        .bus_err_o      (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic int classify(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        case (op)
            6'b001101, 6'b001100, 6'b001001, 6'b001111: return K_IALU;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b000101: return K_BNE;
            6'b000010: return K_J;
            6'b000011: return K_JAL;
            6'b000000: begin
                if (fn == 6'b100001 || fn == 6'b100011 || fn == 6'b100100 || fn == 6'b100101)
                    return K_RALU;
                if (fn == 6'b001000)
                    return K_JR;
                return K_INV;
            end
            default: return K_INV;
        endcase
    endfunction

    function automatic obs_t mk(input int st);
        obs_t o;
        o = '0;
        o.st = 3'(st);
        return o;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [31:0] mkinst(input logic [5:0] op, input logic [5:0] fn);
        logic [31:0] v;
        v = $urandom;
        v[31:26] = op;
        v[5:0] = fn;
        return v;
    endfunction

    // One cycle: drive inputs after the falling edge, then compare outputs.
    task automatic step(input obs_t exp, input logic rdy, input logic z,
                        input logic [31:0] ins, input logic r, input string tag);
        obs_t o;
        @(negedge clk);
        rst = r;
        mem_ready = rdy;
        zero = z;
        inst = ins;
        #1;
        o = '{st: state_o, req: mem_req_o, we: mem_we_o, irw: ir_write_o,
              pcw: pc_write_o, rgw: reg_write_o, pcs: pc_src_o, rdst: reg_dst_o,
              wbs: wb_sel_o, alub: alu_src_b_o, ret: retire_o,
              inv: inst_invalid_o, berr: bus_err_o};
        total++;
        assert (o === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, exp);
        end
    endtask

    // Runs one instruction from FETCH until it returns to FETCH.
    // f0: fetch wait cycles already spent; fw/mw: index of the ready cycle
    // in FETCH/MEM (>= TO means memory never answers).
    task automatic run_instr(input logic [31:0] ins, input int f0, input int fw,
                             input int mw, input logic z, input string tag);
        obs_t e;
        int   c;
        int   i;
        c = classify(ins);
        i = f0;
        forever begin
            e = mk(0);
            e.req = 1'b1;
            if (i == fw) begin
                e.irw = 1'b1;
                e.pcw = 1'b1;
                step(e, 1'b1, rb(), ins, 1'b0, {tag, "_fetch"});
                break;
            end else if (i == TO - 1) begin
                e.berr = 1'b1;
                step(e, 1'b0, rb(), ins, 1'b0, {tag, "_fetch_timeout"});
                return;
            end
            step(e, 1'b0, rb(), ins, 1'b0, {tag, "_fetch_wait"});
            i++;
        end

        e = mk(1);
        case (c)
            K_J:   begin e.pcw = 1'b1; e.pcs = 2'b10; e.ret = 1'b1; end
            K_JR:  begin e.pcw = 1'b1; e.pcs = 2'b11; e.ret = 1'b1; end
            K_JAL: begin e.pcw = 1'b1; e.pcs = 2'b10; end
            K_INV: e.inv = 1'b1;
            default: ;
        endcase
        step(e, rb(), rb(), ins, 1'b0, {tag, "_decode"});
        if (c == K_J || c == K_JR || c == K_INV) return;

        if (c != K_JAL) begin
            e = mk(2);
            e.alub = (c == K_IALU || c == K_LW || c == K_SW);
            if (c == K_BEQ || c == K_BNE) begin
                e.pcw = (c == K_BEQ) ? z : !z;
                e.pcs = 2'b01;
                e.ret = 1'b1;
            end
            step(e, rb(), z, $urandom, 1'b0, {tag, "_exec"});
            if (c == K_BEQ || c == K_BNE) return;
        end

        if (c == K_LW || c == K_SW) begin
            i = 0;
            forever begin
                e = mk(3);
                e.req = 1'b1;
                e.we = (c == K_SW);
                if (i == mw) begin
                    e.ret = (c == K_SW);
                    step(e, 1'b1, rb(), $urandom, 1'b0, {tag, "_mem_done"});
                    break;
                end else if (i == TO - 1) begin
                    e.berr = 1'b1;
                    step(e, 1'b0, rb(), $urandom, 1'b0, {tag, "_mem_timeout"});
                    return;
                end
                step(e, 1'b0, rb(), $urandom, 1'b0, {tag, "_mem_wait"});
                i++;
            end
            if (c == K_SW) return;
        end

        e = mk(4);
        e.rgw = 1'b1;
        e.ret = 1'b1;
        case (c)
            K_RALU: e.rdst = 2'b01;
            K_LW:   e.wbs = 2'b01;
            K_JAL:  begin e.rdst = 2'b10; e.wbs = 2'b10; end
            default: ;
        endcase
        step(e, rb(), rb(), $urandom, 1'b0, {tag, "_wb"});
    endtask

    initial begin
        obs_t e;
        logic [31:0] ins;
        int k;
        int fw;
        int mw;
        logic [5:0] fn;

        total = 0;
        bad = 0;
        rst = 1'b1;
        inst = '0;
        mem_ready = 1'b1;
        zero = 1'b0;
        repeat (2) @(posedge clk);

        // Reset held: everything low even with memory ready.
        step(mk(0), 1'b1, 1'b0, mkinst(6'b001101, 6'd0), 1'b1, "reset_hold");
        // First cycle after reset: plain fetch request.
        e = mk(0);
        e.req = 1'b1;
        step(e, 1'b0, 1'b0, mkinst(6'b001101, 6'd0), 1'b0, "post_reset");

        // ORI, fetch completes on the next cycle.
        run_instr(mkinst(6'b001101, 6'd0), 1, 1, 0, 1'b0, "ori");
        run_instr(mkinst(6'b001101, 6'd0), 0, 0, 0, 1'b0, "ori2");
        run_instr(mkinst(6'b100011, 6'd7), 0, 0, 3, 1'b0, "lw_wait3");
        run_instr(mkinst(6'b101011, 6'd7), 0, 2, 2, 1'b0, "sw_wait2");
        run_instr(mkinst(6'b000100, 6'd0), 0, 0, 0, 1'b1, "beq_taken");
        run_instr(mkinst(6'b000100, 6'd0), 0, 0, 0, 1'b0, "beq_not");
        run_instr(mkinst(6'b000101, 6'd0), 0, 0, 0, 1'b1, "bne_not");
        run_instr(mkinst(6'b000101, 6'd0), 0, 0, 0, 1'b0, "bne_taken");
        run_instr(mkinst(6'b000011, 6'd0), 0, 0, 0, 1'b0, "jal");
        run_instr(mkinst(6'b000010, 6'd0), 0, 0, 0, 1'b0, "j");
        run_instr(mkinst(6'b000000, 6'b001000), 0, 0, 0, 1'b0, "jr");
        run_instr(mkinst(6'b000000, 6'b100001), 0, 0, 0, 1'b0, "addu");
        run_instr(mkinst(6'b000000, 6'b111111), 0, 0, 0, 1'b0, "bad_funct");
        run_instr(mkinst(6'b111111, 6'd0), 0, 0, 0, 1'b0, "bad_op");
        run_instr(mkinst(6'b001111, 6'd0), 0, 99, 0, 1'b0, "fetch_timeout");
        run_instr(mkinst(6'b001001, 6'd0), 0, TO - 1, 0, 1'b0, "fetch_ready_last");
        run_instr(mkinst(6'b100011, 6'd0), 0, 0, 99, 1'b0, "lw_mem_timeout");
        run_instr(mkinst(6'b101011, 6'd0), 0, 0, TO - 1, 1'b0, "sw_ready_last");

        // Reset during an SW memory wait.
        ins = mkinst(6'b101011, 6'd0);
        e = mk(0); e.req = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
        step(e, 1'b1, 1'b0, ins, 1'b0, "swrst_fetch");
        step(mk(1), 1'b0, 1'b0, ins, 1'b0, "swrst_decode");
        e = mk(2); e.alub = 1'b1;
        step(e, 1'b0, 1'b0, ins, 1'b0, "swrst_exec");
        e = mk(3); e.req = 1'b1; e.we = 1'b1;
        step(e, 1'b0, 1'b0, ins, 1'b0, "swrst_mem_wait0");
        step(e, 1'b0, 1'b0, ins, 1'b0, "swrst_mem_wait1");
        step(mk(0), 1'b1, 1'b0, ins, 1'b1, "swrst_in_reset");
        e = mk(0); e.req = 1'b1;
        step(e, 1'b0, 1'b0, ins, 1'b0, "swrst_after");
        run_instr(mkinst(6'b001100, 6'd0), 1, 2, 0, 1'b0, "andi_after_rst");

        // Random instruction mix with random memory latencies.
        for (int n = 0; n < 120; n++) begin
            k = $urandom_range(0, 15);
            fn = 6'($urandom);
            case (k)
                0:  ins = mkinst(6'b001101, fn);
                1:  ins = mkinst(6'b001100, fn);
                2:  ins = mkinst(6'b001001, fn);
                3:  ins = mkinst(6'b001111, fn);
                4: begin
                    case ($urandom_range(0, 3))
                        0: fn = 6'b100001;
                        1: fn = 6'b100011;
                        2: fn = 6'b100100;
                        default: fn = 6'b100101;
                    endcase
                    ins = mkinst(6'b000000, fn);
                end
                5:  ins = mkinst(6'b000000, 6'b001000);
                6, 14: ins = mkinst(6'b100011, fn);
                7, 15: ins = mkinst(6'b101011, fn);
                8:  ins = mkinst(6'b000100, fn);
                9:  ins = mkinst(6'b000101, fn);
                10: ins = mkinst(6'b000010, fn);
                11: ins = mkinst(6'b000011, fn);
                12: ins = mkinst(6'($urandom), fn);
                default: ins = mkinst(6'b000000, fn);
            endcase
            fw = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 3);
            mw = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 3);
            run_instr(ins, 0, fw, mw, rb(), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
